// File: rtl/pc_next_pkg.sv
// Shared types and constants for the next-PC controller: run/halt states,
// widths, and the small arithmetic helpers used by the next-PC mux.
package pc_next_pkg;

  localparam int PC_W      = 16;
  localparam int LUT_DEPTH = 16;
  localparam int LUT_IDX_W = 4;
  localparam int OFF_W     = 8;

  localparam logic [PC_W-1:0] RESET_PC  = 16'h0000;
  localparam logic [PC_W-1:0] COUNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  function automatic logic [PC_W-1:0] sext_offset(input logic [OFF_W-1:0] off);
    return {{(PC_W-OFF_W){off[OFF_W-1]}}, off};
  endfunction

  // Retired-instruction counter sticks at its maximum instead of wrapping.
  function automatic logic [PC_W-1:0] sat_inc(input logic [PC_W-1:0] val);
    logic [PC_W-1:0] res;
    if (val == COUNT_MAX) begin
      res = val;
    end else begin
      res = val + 16'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/pc_next_ctrl_jump_lut.sv
// Writable jump-target table: one synchronous write port, one combinational
// read port; a same-edge write is seen by reads only after that edge.
module jump_lut
  import pc_next_pkg::*;
(
  input  logic                 CLK,
  input  logic                 reset_ctrl,
  input  logic                 we,
  input  logic [LUT_IDX_W-1:0] waddr,
  input  logic [PC_W-1:0]      wdata,
  input  logic [LUT_IDX_W-1:0] raddr,
  output logic [PC_W-1:0]      rdata
);

  logic [PC_W-1:0] mem_r [LUT_DEPTH];

  // Table storage: whole-table clear on reset, otherwise single-entry write.
  always_ff @(posedge CLK) begin
    if (reset_ctrl) begin
      for (int i = 0; i < LUT_DEPTH; i++) begin
        mem_r[i] <= RESET_PC;
      end
    end else if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/pc_next_ctrl.sv
// Next-PC controller: run/halt FSM, next-PC selection (hold, increment,
// relative or table branch, start vector) and saturating retired counter.
module pc_next_ctrl
  import pc_next_pkg::*;
(
  input  logic                 CLK,
  input  logic                 reset_ctrl,
  input  logic                 start,
  input  logic [PC_W-1:0]      start_addr,
  input  logic [PC_W-1:0]      pc_in,
  input  logic                 stall_in,
  input  logic                 halt_in,
  input  logic                 branch_ctrl,
  input  logic                 branch_rel,
  input  logic [OFF_W-1:0]     offset_in,
  input  logic [LUT_IDX_W-1:0] branch_sel,
  input  logic                 lut_we,
  input  logic [LUT_IDX_W-1:0] lut_waddr,
  input  logic [PC_W-1:0]      lut_wdata,
  output logic [PC_W-1:0]      pcnext_out,
  output logic                 running,
  output logic                 done,
  output logic [PC_W-1:0]      instr_count
);

  state_t          state_r;
  state_t          state_nxt_s;
  logic [PC_W-1:0] count_r;
  logic [PC_W-1:0] count_nxt_s;
  logic [PC_W-1:0] pcnext_s;
  logic [PC_W-1:0] lut_target_s;
  logic            running_r;
  logic            done_r;

  jump_lut u_jump_lut (
    .CLK        (CLK),
    .reset_ctrl (reset_ctrl),
    .we         (lut_we),
    .waddr      (lut_waddr),
    .wdata      (lut_wdata),
    .raddr      (branch_sel),
    .rdata      (lut_target_s)
  );

  // One decision drives both the 0-cycle next-PC value and the registered state.
  always_comb begin
    pcnext_s    = pc_in;
    state_nxt_s = state_r;
    count_nxt_s = count_r;
    if (reset_ctrl) begin
      pcnext_s    = RESET_PC;
      state_nxt_s = IDLE;
      count_nxt_s = 16'h0000;
    end else begin
      case (state_r)
        IDLE, HALT: begin
          if (start) begin
            pcnext_s    = start_addr;
            state_nxt_s = RUN;
            count_nxt_s = 16'h0000;
          end else begin
            pcnext_s = pc_in;
          end
        end
        RUN: begin
          if (stall_in) begin
            pcnext_s = pc_in;
          end else if (halt_in) begin
            pcnext_s    = pc_in;
            state_nxt_s = HALT;
            count_nxt_s = sat_inc(count_r);
          end else if (branch_ctrl) begin
            if (branch_rel) begin
              pcnext_s = pc_in + sext_offset(offset_in);
            end else begin
              pcnext_s = lut_target_s;
            end
            count_nxt_s = sat_inc(count_r);
          end else begin
            pcnext_s    = pc_in + 16'd1;
            count_nxt_s = sat_inc(count_r);
          end
        end
        default: begin
          pcnext_s    = pc_in;
          state_nxt_s = IDLE;
        end
      endcase
    end
  end

  // FSM state, counter and status flags, all taken from the next-state decode.
  always_ff @(posedge CLK) begin
    if (reset_ctrl) begin
      state_r   <= IDLE;
      count_r   <= 16'h0000;
      running_r <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      count_r   <= count_nxt_s;
      running_r <= (state_nxt_s == RUN);
      done_r    <= (state_nxt_s == HALT);
    end
  end

  assign pcnext_out  = pcnext_s;
  assign running     = running_r;
  assign done        = done_r;
  assign instr_count = count_r;

endmodule

// File: tb/tb_pc_next_ctrl.sv
// Self-checking bench for pc_next_ctrl: directed scenarios plus randomized
// traffic compared against a behavioural model of the controller.
module tb_pc_next_ctrl;

  logic        CLK = 1'b0;
  logic        reset_ctrl;
  logic        start;
  logic [15:0] start_addr;
  logic [15:0] pc_in;
  logic        stall_in;
  logic        halt_in;
  logic        branch_ctrl;
  logic        branch_rel;
  logic [7:0]  offset_in;
  logic [3:0]  branch_sel;
  logic        lut_we;
  logic [3:0]  lut_waddr;
  logic [15:0] lut_wdata;
  logic [15:0] pcnext_out;
  logic        running;
  logic        done;
  logic [15:0] instr_count;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model: executing flag, halted flag, counter, table, PC register.
  bit          m_run;
  bit          m_halt;
  int          m_cnt;
  logic [15:0] m_lut [16];
  logic [15:0] m_pc;

  pc_next_ctrl dut (
    .CLK         (CLK),
    .reset_ctrl  (reset_ctrl),
    .start       (start),
    .start_addr  (start_addr),
    .pc_in       (pc_in),
    .stall_in    (stall_in),
    .halt_in     (halt_in),
    .branch_ctrl (branch_ctrl),
    .branch_rel  (branch_rel),
    .offset_in   (offset_in),
    .branch_sel  (branch_sel),
    .lut_we      (lut_we),
    .lut_waddr   (lut_waddr),
    .lut_wdata   (lut_wdata),
    .pcnext_out  (pcnext_out),
    .running     (running),
    .done        (done),
    .instr_count (instr_count)
  );

  always #5 CLK = ~CLK;

  function automatic logic [15:0] model_next();
    int off;
    int p;
    if (reset_ctrl) return 16'h0000;
    if (!m_run) return start ? start_addr : pc_in;
    if (stall_in || halt_in) return pc_in;
    if (branch_ctrl) begin
      if (!branch_rel) return m_lut[branch_sel];
      off = int'(offset_in);
      if (off > 127) off = off - 256;
      p = (int'(pc_in) + off + 65536) % 65536;
      return p[15:0];
    end
    p = (int'(pc_in) + 1) % 65536;
    return p[15:0];
  endfunction

  task automatic model_edge();
    logic [15:0] nxt;
    if (reset_ctrl) begin
      m_run = 1'b0;
      m_halt = 1'b0;
      m_cnt = 0;
      for (int i = 0; i < 16; i++) m_lut[i] = 16'h0000;
      m_pc = 16'h0000;
    end else begin
      nxt = model_next();
      if (lut_we) m_lut[lut_waddr] = lut_wdata;
      if (!m_run) begin
        if (start) begin
          m_run = 1'b1;
          m_halt = 1'b0;
          m_cnt = 0;
        end
      end else if (!stall_in) begin
        if (m_cnt < 65535) m_cnt = m_cnt + 1;
        if (halt_in) begin
          m_run = 1'b0;
          m_halt = 1'b1;
        end
      end
      m_pc = nxt;
    end
  endtask

  task automatic clear_ctrl();
    start = 1'b0; stall_in = 1'b0; halt_in = 1'b0;
    branch_ctrl = 1'b0; branch_rel = 1'b0; offset_in = 8'h00; branch_sel = 4'h0;
    lut_we = 1'b0; lut_waddr = 4'h0; lut_wdata = 16'h0000;
  endtask

  // One clock: check the combinational next PC, clock, check registered state.
  task automatic cycle(input string tag);
    logic [15:0] exp_pc;
    #2;
    exp_pc = model_next();
    vectors++;
    if (pcnext_out !== exp_pc) begin
      miscompares++;
      $display("FAIL %s pcnext_out got %h expected %h", tag, pcnext_out, exp_pc);
    end
    @(posedge CLK);
    model_edge();
    #1;
    vectors++;
    if (running !== m_run) begin
      miscompares++;
      $display("FAIL %s running got %b expected %b", tag, running, m_run);
    end
    vectors++;
    if (done !== m_halt) begin
      miscompares++;
      $display("FAIL %s done got %b expected %b", tag, done, m_halt);
    end
    vectors++;
    if (instr_count !== m_cnt[15:0]) begin
      miscompares++;
      $display("FAIL %s instr_count got %h expected %h", tag, instr_count, m_cnt[15:0]);
    end
    pc_in = m_pc;
  endtask

  task automatic test_reset();
    reset_ctrl = 1'b1;
    clear_ctrl();
    start = 1'b1; start_addr = 16'h1234; lut_we = 1'b1; lut_wdata = 16'hBEEF;
    for (int i = 0; i < 3; i++) begin
      pc_in = 16'($urandom);
      cycle("reset");
    end
    reset_ctrl = 1'b0;
    clear_ctrl();
    pc_in = 16'($urandom);
    cycle("idle_hold");
  endtask

  task automatic test_sequential();
    start = 1'b1; start_addr = 16'h0010; pc_in = 16'h7777;
    cycle("seq_start");
    start = 1'b0;
    for (int i = 0; i < 3; i++) cycle("seq_inc");
    vectors++;
    if (instr_count !== 16'd3 || running !== 1'b1) begin
      miscompares++;
      $display("FAIL seq_count count=%h running=%b required 0003/1", instr_count, running);
    end
  endtask

  task automatic test_rel_branch();
    pc_in = 16'h0005; branch_ctrl = 1'b1; branch_rel = 1'b1; offset_in = 8'hF8;
    #2;
    vectors++;
    if (pcnext_out !== 16'hFFFD) begin
      miscompares++;
      $display("FAIL rel_neg got %h required FFFD", pcnext_out);
    end
    cycle("rel_neg");
    clear_ctrl();
    pc_in = 16'hFFFF;
    #2;
    vectors++;
    if (pcnext_out !== 16'h0000) begin
      miscompares++;
      $display("FAIL inc_wrap got %h required 0000", pcnext_out);
    end
    cycle("inc_wrap");
    for (int i = 0; i < 200; i++) begin
      branch_ctrl = 1'b1; branch_rel = 1'b1;
      offset_in = 8'($urandom);
      if ($urandom_range(0, 3) == 0) pc_in = 16'($urandom);
      cycle("rel_rand");
    end
    clear_ctrl();
  endtask

  task automatic test_lut_branch();
    stall_in = 1'b1; lut_we = 1'b1; lut_waddr = 4'd3; lut_wdata = 16'h0200;
    cycle("lut_write");
    clear_ctrl();
    branch_ctrl = 1'b1; branch_sel = 4'd3;
    lut_we = 1'b1; lut_waddr = 4'd3; lut_wdata = 16'h0300;
    #2;
    vectors++;
    if (pcnext_out !== 16'h0200) begin
      miscompares++;
      $display("FAIL lut_old got %h required 0200", pcnext_out);
    end
    cycle("lut_old");
    lut_we = 1'b0;
    #2;
    vectors++;
    if (pcnext_out !== 16'h0300) begin
      miscompares++;
      $display("FAIL lut_new got %h required 0300", pcnext_out);
    end
    cycle("lut_new");
    for (int i = 0; i < 200; i++) begin
      lut_we = ($urandom_range(0, 1) == 1);
      lut_waddr = 4'($urandom);
      lut_wdata = 16'($urandom);
      branch_ctrl = ($urandom_range(0, 2) != 0);
      branch_sel = 4'($urandom);
      cycle("lut_rand");
    end
    clear_ctrl();
  endtask

  task automatic test_stall_halt();
    int saved;
    saved = m_cnt;
    stall_in = 1'b1; halt_in = 1'b1;
    cycle("stall_halt");
    vectors++;
    if (running !== 1'b1 || done !== 1'b0 || instr_count !== saved[15:0]) begin
      miscompares++;
      $display("FAIL stall_over_halt running=%b done=%b count=%h required 1/0/%h",
               running, done, instr_count, saved[15:0]);
    end
    stall_in = 1'b0;
    cycle("halt");
    vectors++;
    if (done !== 1'b1 || running !== 1'b0) begin
      miscompares++;
      $display("FAIL halt_done done=%b running=%b required 1/0", done, running);
    end
    clear_ctrl();
    branch_ctrl = 1'b1; branch_rel = 1'b1; offset_in = 8'h10;
    for (int i = 0; i < 3; i++) cycle("halt_frozen");
    clear_ctrl();
    start = 1'b1; start_addr = 16'($urandom);
    cycle("restart");
    vectors++;
    if (done !== 1'b0 || instr_count !== 16'h0000) begin
      miscompares++;
      $display("FAIL restart done=%b count=%h required 0/0000", done, instr_count);
    end
    clear_ctrl();
    cycle("restart_run");
  endtask

  task automatic test_reset_mid_run();
    stall_in = 1'b1; lut_we = 1'b1; lut_waddr = 4'd5; lut_wdata = 16'hABCD;
    cycle("pre_reset_write");
    clear_ctrl();
    reset_ctrl = 1'b1; start = 1'b1; start_addr = 16'h0040;
    lut_we = 1'b1; lut_waddr = 4'd5; lut_wdata = 16'h1234;
    cycle("reset_mid_run");
    reset_ctrl = 1'b0;
    clear_ctrl();
    start = 1'b1; start_addr = 16'h0040;
    cycle("post_reset_start");
    clear_ctrl();
    branch_ctrl = 1'b1; branch_sel = 4'd5;
    #2;
    vectors++;
    if (pcnext_out !== 16'h0000) begin
      miscompares++;
      $display("FAIL lut_cleared got %h required 0000", pcnext_out);
    end
    cycle("lut_cleared");
    clear_ctrl();
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      reset_ctrl = ($urandom_range(0, 199) == 0);
      start = ($urandom_range(0, 19) == 0);
      start_addr = 16'($urandom);
      stall_in = ($urandom_range(0, 5) == 0);
      halt_in = ($urandom_range(0, 39) == 0);
      branch_ctrl = ($urandom_range(0, 2) == 0);
      branch_rel = ($urandom_range(0, 1) == 1);
      offset_in = 8'($urandom);
      branch_sel = 4'($urandom);
      lut_we = ($urandom_range(0, 3) == 0);
      lut_waddr = 4'($urandom);
      lut_wdata = 16'($urandom);
      if ($urandom_range(0, 7) == 0) pc_in = 16'($urandom);
      cycle("random");
    end
    reset_ctrl = 1'b0;
    clear_ctrl();
  endtask

  task automatic test_saturation();
    start = 1'b1; start_addr = 16'($urandom);
    cycle("sat_start");
    clear_ctrl();
    for (int i = 0; i < 65540; i++) cycle("sat_run");
    vectors++;
    if (instr_count !== 16'hFFFF || running !== 1'b1) begin
      miscompares++;
      $display("FAIL saturate count=%h running=%b required FFFF/1", instr_count, running);
    end
  endtask

  initial begin
    m_run = 1'b0; m_halt = 1'b0; m_cnt = 0; m_pc = 16'h0000;
    for (int i = 0; i < 16; i++) m_lut[i] = 16'h0000;
    reset_ctrl = 1'b1; start_addr = 16'h0000; pc_in = 16'h0000;
    clear_ctrl();
    test_reset();
    test_sequential();
    test_rel_branch();
    test_lut_branch();
    test_stall_halt();
    test_reset_mid_run();
    test_random();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pc_next_ctrl.md
# pc_next_ctrl

Next-PC controller sitting directly upstream of the program counter register: it takes the current PC back from that register and drives the 16-bit next-PC value the register loads on every clock edge. It owns the run/halt state machine (start/done handshake with the testbench or host), sequential increment, relative and table-based branching, stall hold, and a retired-instruction counter. Its branch-target table is a small writable jump LUT.

## Interface
- PC_W, 16, program counter width
- LUT_DEPTH, 16, jump-target table entries (index width log2 = 4)
- CLK  in  1  clock; all state updates on posedge
- reset_ctrl  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse: begin execution at start_addr
- start_addr  in  16  first PC of program
- pc_in  in  16  current PC from the PC register
- stall_in  in  1  hold PC this cycle
- halt_in  in  1  decoded halt instruction at pc_in
- branch_ctrl  in  1  branch taken this cycle
- branch_rel  in  1  1 = PC-relative, 0 = absolute via LUT
- offset_in  in  8  signed relative offset
- branch_sel  in  4  LUT index for absolute branch
- lut_we  in  1  LUT write enable
- lut_waddr  in  4  LUT write index
- lut_wdata  in  16  LUT write data
- pcnext_out  out  16  next PC to PC register
- running  out  1  state == RUN
- done  out  1  program halted
- instr_count  out  16  retired-instruction count

## Operation
- States: IDLE, RUN, HALT. Reset -> IDLE.
- IDLE: pcnext_out = pc_in (hold). start -> RUN, pcnext_out = start_addr that cycle, instr_count cleared to 0.
- RUN, priority stall_in > halt_in > branch_ctrl > increment:
  - stall_in: pcnext_out = pc_in; no count.
  - halt_in: pcnext_out = pc_in; -> HALT; count +1.
  - branch_ctrl & branch_rel: pcnext_out = pc_in + sign-extended offset_in, modulo 2^16; count +1.
  - branch_ctrl & !branch_rel: pcnext_out = LUT[branch_sel]; count +1.
  - else pcnext_out = pc_in + 1, FFFF wraps to 0000; count +1.
  - start ignored in RUN.
- HALT: pcnext_out = pc_in; done = 1; start -> RUN exactly as from IDLE (restart, count cleared).
- instr_count saturates at FFFF.
- LUT: write on posedge when lut_we, in any state; read is combinational; same-cycle write and read of one index returns old value.

## Timing
- Reset values: state IDLE, running 0, done 0, instr_count 0, all LUT entries 0000; pcnext_out = 0000 while reset_ctrl high.
- pcnext_out combinational from pc_in and controls (0-cycle); PC register reflects it next edge.
- running, done, instr_count registered: update the edge after the causing cycle. done rises one cycle after the halt cycle, falls one cycle after start.
- reset_ctrl mid-RUN: next edge forces IDLE, clears count, done, LUT; overrides start/lut_we in same cycle.

## Structure
- Package pc_next_pkg: state enum (IDLE, RUN, HALT), PC_W, LUT_DEPTH, LUT_IDX_W, RESET_PC = 16'h0000.
- Sub-module jump_lut: LUT_DEPTH x PC_W register file, one sync write port, one comb read port, synchronous clear on reset_ctrl.
- Top holds FSM, next-PC mux, counter.

## Test plan
- Reset then start with start_addr=0010, no branches, 4 cycles -> PC sequence 0010,0011,0012,0013; running=1; instr_count=3 after 4th edge.
- pc_in=0005, branch_rel=1, offset_in=F8 (-8) -> pcnext_out=FFFD; pc_in=FFFF, no branch -> pcnext_out=0000.
- Write LUT[3]=0200, then branch_ctrl=1, branch_rel=0, branch_sel=3 -> pcnext_out=0200; same-cycle rewrite of LUT[3]=0300 -> still 0200, next use 0300.
- stall_in=1 and halt_in=1 together -> PC held, stays RUN, count unchanged; drop stall -> HALT, done=1 one edge later, PC frozen; start again -> done=0, instr_count=0, PC=start_addr.
- reset_ctrl asserted mid-RUN with lut_we=1 -> IDLE, done=0, instr_count=0, LUT entry reads 0000, pcnext_out=0000.
- Drive 65 540 non-stall RUN cycles -> instr_count saturates at FFFF.
